// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, instruction field positions and sequencer state
// type for the ALU sequencer slice.
package alu_seq_pkg;

  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_SHL  = 7'd2;
  localparam logic [6:0] OP_SHR  = 7'd3;
  localparam logic [6:0] OP_MOV  = 7'd4;
  localparam logic [6:0] OP_LDL  = 7'd5;
  localparam logic [6:0] OP_LDH  = 7'd6;
  localparam logic [6:0] OP_MOV2 = 7'd7;
  localparam logic [6:0] OP_EQ   = 7'd8;
  localparam logic [6:0] OP_LT   = 7'd9;
  localparam logic [6:0] OP_GT   = 7'd10;
  localparam logic [6:0] OP_NOT  = 7'd11;
  localparam logic [6:0] OP_AND  = 7'd12;
  localparam logic [6:0] OP_NOT2 = 7'd13;
  localparam logic [6:0] OP_JMP  = 7'd14;
  localparam logic [6:0] OP_JF   = 7'd15;
  localparam logic [6:0] OP_HALT = 7'd127;

  localparam int OP_LSB  = 0;
  localparam int OP_W    = 7;
  localparam int RD_LSB  = 7;
  localparam int RA_LSB  = 11;
  localparam int RB_LSB  = 16;
  localparam int IMM_LSB = 16;
  localparam int IMM_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_e;

  function automatic logic writes_reg(input logic [6:0] op);
    return (op <= OP_MOV2);
  endfunction

  function automatic logic writes_flags(input logic [6:0] op);
    return (op >= OP_EQ) && (op <= OP_NOT2);
  endfunction

  function automatic logic is_jump(input logic [6:0] op);
    return (op == OP_JMP) || (op == OP_JF);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-fetch handshake and ALU drive/result bundle between the
// sequencer (master) and the memory/ALU side (slave).
interface alu_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [31:0] alu_reg8;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic        alu_F1;
  logic        alu_F2;
  logic [6:0]  alu_instr;

  logic [31:0] alu_C;
  logic        alu_F3;
  logic        alu_addrch;
  logic [31:0] alu_naddr;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output alu_A, alu_B, alu_reg8, alu_value, alu_highlow, alu_F1, alu_F2, alu_instr,
    input  alu_C, alu_F3, alu_addrch, alu_naddr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  alu_A, alu_B, alu_reg8, alu_value, alu_highlow, alu_F1, alu_F2, alu_instr,
    output alu_C, alu_F3, alu_addrch, alu_naddr
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// 16x32 register file: one synchronous write port, three asynchronous reads
// (ra, rb and the fixed jump-target register r8), synchronous clear.
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [REG_AW-1:0] ra_addr_i,
  input  logic [REG_AW-1:0] rb_addr_i,
  output logic [31:0]       ra_data_o,
  output logic [31:0]       rb_data_o,
  output logic [31:0]       r8_data_o
);

  logic [31:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];
  assign r8_data_o = regs_q[8];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/exec/writeback sequencer that owns the PC, register file and
// F1/F2 flags, and drives an external combinational ALU.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [6:0]  HALT_OP  = OP_HALT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  alu_sequencer_if.master        bus,
  output logic [31:0]            pc,
  output logic                   halted
);

  seq_state_e        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [OP_W-1:0]   op_q;
  logic [3:0]        rd_q;
  logic [3:0]        ra_q;
  logic [IMM_W-1:0]  imm_q;
  logic [31:0]       a_q, b_q, r8_q;
  logic              f1_q, f2_q;
  logic [31:0]       c_q;
  logic              f3_q, addrch_q;
  logic [31:0]       naddr_q;
  logic              req_q, halted_q;
  logic [6:0]        instr_q;

  logic [31:0]       rf_a, rf_b, rf_r8;
  logic              rf_we;

  assign rf_we = (state_q == S_WB) && writes_reg(op_q);

  seq_regfile u_regfile (
    .clk_i     (clock),
    .rst_i     (reset),
    .we_i      (rf_we),
    .waddr_i   (rd_q),
    .wdata_i   (c_q),
    .ra_addr_i (ra_q),
    .rb_addr_i (imm_q[3:0]),
    .ra_data_o (rf_a),
    .rb_data_o (rf_b),
    .r8_data_o (rf_r8)
  );

  // Next-state and PC update; the PC only moves in WB or when resuming from HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        if (bus.imem_ack) state_d = S_DECODE;
        else              state_d = S_FETCH;
      end
      S_DECODE: begin
        if (op_q == HALT_OP) state_d = S_HALT;
        else                 state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        state_d = S_FETCH;
        if (is_jump(op_q) && addrch_q) pc_d = naddr_q;
        else                           pc_d = pc_q + 32'd1;
      end
      S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
          pc_d    = pc_q + 32'd1;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and outputs registered from the next state so they change cleanly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      instr_q  <= 7'd0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= (state_d == S_FETCH);
      halted_q <= (state_d == S_HALT);
      instr_q  <= (state_d == S_EXEC) ? op_q : 7'd0;
      if ((state_q == S_WB) && writes_flags(op_q)) begin
        f2_q <= f1_q;
        f1_q <= f3_q;
      end
    end
  end

  // Datapath latches: instruction fields, operands, and sampled ALU results.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= 7'd0;
      rd_q     <= 4'd0;
      ra_q     <= 4'd0;
      imm_q    <= 16'h0000;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      r8_q     <= 32'h0000_0000;
      c_q      <= 32'h0000_0000;
      f3_q     <= 1'b0;
      addrch_q <= 1'b0;
      naddr_q  <= 32'h0000_0000;
    end else begin
      if ((state_q == S_FETCH) && bus.imem_ack) begin
        op_q  <= bus.imem_rdata[OP_LSB +: OP_W];
        rd_q  <= bus.imem_rdata[RD_LSB +: 4];
        ra_q  <= bus.imem_rdata[RA_LSB +: 4];
        imm_q <= bus.imem_rdata[IMM_LSB +: IMM_W];
      end
      if (state_q == S_DECODE) begin
        a_q  <= rf_a;
        b_q  <= rf_b;
        r8_q <= rf_r8;
      end
      if (state_q == S_EXEC) begin
        c_q      <= bus.alu_C;
        f3_q     <= bus.alu_F3;
        addrch_q <= bus.alu_addrch;
        naddr_q  <= bus.alu_naddr;
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.alu_A       = a_q;
  assign bus.alu_B       = b_q;
  assign bus.alu_reg8    = r8_q;
  assign bus.alu_value   = imm_q;
  assign bus.alu_highlow = (op_q == OP_LDH);
  assign bus.alu_F1      = f1_q;
  assign bus.alu_F2      = f2_q;
  assign bus.alu_instr   = instr_q;
  assign pc              = pc_q;
  assign halted          = halted_q;

endmodule
